exec_unit: RTL
==============

Name: exec_unit

Overview:
- Execute stage directly downstream of the register file. It consumes the two read operands and produces the write-back bundle (write enable, address, data) that drives the register file's write port.
- Single-cycle ops: ADD, SUB, AND, OR, XOR.
- Multi-cycle iterative ops: SHL, SHR (one bit per cycle) and MUL (shift-add, W cycles).
- Start/Busy/Done handshake toward the controller.

Parameters:
- W, 8, data path width; matches the register file width.
- A, 3, register address width; matches the register file address width.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; accepted only when Busy=0.
- Op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
- OperandA  input  W  first operand (register file DataOutA).
- OperandB  input  W  second operand / shift count (register file DataOutB).
- DstAddr  input  A  destination register index.
- Busy  output  1  high whenever state is not IDLE.
- Done  output  1  one-cycle pulse when the result is valid.
- WrEn  output  1  write enable to the register file; identical timing to Done.
- WrAddr  output  A  destination index; valid while WrEn=1.
- WrData  output  W  result; valid while WrEn=1.
- CarryFlag  output  1  carry/borrow/overflow of the last completed op.
- ZeroFlag  output  1  high if WrData was 0 on the last completed op.

Behaviour:
- Reset (synchronous, active-high): state to IDLE. Busy, Done, WrEn, WrAddr, WrData, CarryFlag, ZeroFlag all reset to 0. Internal counters and accumulators cleared.
- States:
  - IDLE: Start=1 latches Op, OperandA, OperandB, DstAddr.
    - ADD/SUB/AND/OR/XOR go to DONE.
    - SHL/SHR with count = OperandB[$clog2(W)-1:0]: count=0 goes to DONE; otherwise goes to SHIFT.
    - MUL goes to MUL.
  - SHIFT: shift the working value by 1 bit per cycle; the bit shifted out is captured as carry; decrement count. When count reaches 1, the final shift is performed and the FSM goes to DONE.
  - MUL: 2W-bit shift-add, one multiplier bit per cycle, exactly W cycles, then DONE.
  - DONE: Done=1, WrEn=1, WrData and WrAddr driven, flags updated. Next state is IDLE unconditionally.
- Latency, with Start sampled at edge k:
  - Logical and arithmetic ops: WrEn high in the cycle after edge k+1.
  - Shift by n: WrEn high after edge k+1+n (n=0 gives 1 cycle).
  - MUL: WrEn high after edge k+1+W, i.e. 9 cycles for W=8.
- Start while Busy=1, including in the DONE state, is ignored. No queuing. No back-to-back issue.
- Operands are captured at acceptance; later changes on OperandA, OperandB or DstAddr have no effect on the op in flight.
- Arithmetic (all results truncated to W bits):
  - ADD: carry = bit W of A+B.
  - SUB: A-B mod 2^W; carry = borrow (A<B unsigned).
  - AND/OR/XOR: carry = 0.
  - SHL/SHR: logical, zero fill; carry = last bit shifted out; 0 if count=0.
  - MUL: WrData = low W bits of the unsigned product; carry = 1 if the high W bits are nonzero.
- Flags change only in the DONE cycle and hold otherwise.
- WrData and WrAddr hold their last values outside DONE. Only WrEn qualifies a write.
- Reset mid-operation: aborts the op with no WrEn/Done pulse. Busy=0 in the cycle after the reset edge.
- Start asserted together with Reset: Reset wins; the request is dropped.

Optional Feature:
- Macro: EXEC_FLAGS_EN.
- Defined: CarryFlag and ZeroFlag are registered and updated as described in Behaviour.
- Undefined: flag logic is compiled out; CarryFlag and ZeroFlag are tied to 0. All other behaviour and latencies are unchanged.

Test Plan:
- ADD, A=200, B=100, DstAddr=3 -> one cycle later: WrEn=1, WrAddr=3, WrData=44, CarryFlag=1, ZeroFlag=0, Done pulse of 1 cycle.
- SUB, A=5, B=5 -> WrData=0, ZeroFlag=1, CarryFlag=0. Then SUB, A=3, B=5 -> WrData=254, CarryFlag=1.
- SHL, A=0xC1, B=2 -> Busy for 3 cycles; WrEn after edge k+3; WrData=0x04, CarryFlag=1. SHR, A=0x0D, B=0 -> latency 1, WrData=0x0D, CarryFlag=0.
- MUL, A=13, B=20 -> WrEn exactly 9 cycles after Start, WrData=0x04, CarryFlag=1. MUL, A=15, B=17 -> WrData=255, CarryFlag=0.
- Start with ADD asserted at cycle k+2 during a MUL -> ignored: only the MUL result is written, and exactly one WrEn pulse occurs.
- Reset pulsed 4 cycles into a MUL -> no WrEn/Done; all outputs 0 next cycle. A new ADD 1+1 afterwards completes normally with WrData=2.
- Each test is repeated with EXEC_FLAGS_EN undefined -> flags constantly 0.

Source files
------------

// File: rtl/exec_unit_if.sv
// exec_unit_if: request/operand bundle from the controller and register file, plus the
// write-back bundle and status returned by the execute stage.
interface exec_unit_if #(
    parameter int unsigned W = 8,
    parameter int unsigned A = 3
);
    logic         Start;
    logic [2:0]   Op;
    logic [W-1:0] OperandA;
    logic [W-1:0] OperandB;
    logic [A-1:0] DstAddr;
    logic         Busy;
    logic         Done;
    logic         WrEn;
    logic [A-1:0] WrAddr;
    logic [W-1:0] WrData;
    logic         CarryFlag;
    logic         ZeroFlag;

    // Controller side: issues requests, observes status and write-back.
    modport master (
        output Start, Op, OperandA, OperandB, DstAddr,
        input  Busy, Done, WrEn, WrAddr, WrData, CarryFlag, ZeroFlag
    );

    // Execute-unit side.
    modport slave (
        input  Start, Op, OperandA, OperandB, DstAddr,
        output Busy, Done, WrEn, WrAddr, WrData, CarryFlag, ZeroFlag
    );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: execute stage between register file read and write ports.
// Single-cycle ADD/SUB/AND/OR/XOR, iterative SHL/SHR (1 bit/cycle) and MUL (shift-add, W cycles).
// Write-back (WrEn/WrAddr/WrData) is registered on the edge that leaves the DONE state.
// Optional macro EXEC_FLAGS_EN: when defined, CarryFlag/ZeroFlag are registered; otherwise tied 0.
module exec_unit #(
    parameter int unsigned W = 8,
    parameter int unsigned A = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    exec_unit_if.slave exec_bus
);
    localparam int unsigned SW = $clog2(W);
    localparam int unsigned CW = SW + 1;

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;
    localparam logic [2:0] OpShl = 3'd5;
    localparam logic [2:0] OpShr = 3'd6;
    localparam logic [2:0] OpMul = 3'd7;

    typedef enum logic [1:0] {StIdle, StShift, StMul, StDone} state_e;

    state_e         r_state;
    state_e         w_state_next;
    logic [2:0]     r_op;
    logic [W-1:0]   r_a;          // operand A; shifted in place for SHL/SHR
    logic [W-1:0]   r_b;
    logic [A-1:0]   r_dst;
    logic [CW-1:0]  r_cnt;        // remaining shift steps or multiplier bits
    logic [2*W-1:0] r_acc;        // {partial product, remaining multiplier bits}
    logic           r_shift_c;    // last bit shifted out
    logic           r_wr_en;
    logic [A-1:0]   r_wr_addr;
    logic [W-1:0]   r_wr_data;

    logic [CW-1:0]  w_shamt;
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_next;
    logic [W-1:0]   w_result;
    logic           w_carry;

    assign w_shamt = {1'b0, exec_bus.OperandB[SW-1:0]};

    // One shift-add step: add multiplicand when the current multiplier LSB is set, shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_a} : {(W+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; Start is only looked at in IDLE.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (exec_bus.Start) begin
                    if (exec_bus.Op == OpShl || exec_bus.Op == OpShr) begin
                        w_state_next = (w_shamt == '0) ? StDone : StShift;
                    end else if (exec_bus.Op == OpMul) begin
                        w_state_next = StMul;
                    end else begin
                        w_state_next = StDone;
                    end
                end
            end
            StShift: if (r_cnt == CW'(1)) w_state_next = StDone;
            StMul:   if (r_cnt == CW'(1)) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Final result and carry, evaluated while in DONE.
    always_comb begin
        w_result = '0;
        w_carry  = 1'b0;
        case (r_op)
            OpAdd: {w_carry, w_result} = {1'b0, r_a} + {1'b0, r_b};
            OpSub: begin
                w_result = r_a - r_b;
                w_carry  = (r_a < r_b);
            end
            OpAnd: w_result = r_a & r_b;
            OpOr:  w_result = r_a | r_b;
            OpXor: w_result = r_a ^ r_b;
            OpShl, OpShr: begin
                w_result = r_a;
                w_carry  = r_shift_c;
            end
            OpMul: begin
                w_result = r_acc[W-1:0];
                w_carry  = |r_acc[2*W-1:W];
            end
            default: ;
        endcase
    end

    // Operand capture, iterative datapath and registered write-back.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_dst     <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_shift_c <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (exec_bus.Start) begin
                        r_op      <= exec_bus.Op;
                        r_a       <= exec_bus.OperandA;
                        r_b       <= exec_bus.OperandB;
                        r_dst     <= exec_bus.DstAddr;
                        r_cnt     <= (exec_bus.Op == OpMul) ? CW'(W) : w_shamt;
                        r_acc     <= {{W{1'b0}}, exec_bus.OperandB};
                        r_shift_c <= 1'b0;
                    end
                end
                StShift: begin
                    if (r_op == OpShl) begin
                        r_shift_c <= r_a[W-1];
                        r_a       <= r_a << 1;
                    end else begin
                        r_shift_c <= r_a[0];
                        r_a       <= r_a >> 1;
                    end
                    r_cnt <= r_cnt - CW'(1);
                end
                StMul: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt - CW'(1);
                end
                StDone: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_dst;
                    r_wr_data <= w_result;
                end
                default: ;
            endcase
        end
    end

`ifdef EXEC_FLAGS_EN
    logic r_carry;
    logic r_zero;

    // Flags update together with the write-back and hold otherwise.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (r_state == StDone) begin
            r_carry <= w_carry;
            r_zero  <= (w_result == '0);
        end
    end

    assign exec_bus.CarryFlag = r_carry;
    assign exec_bus.ZeroFlag  = r_zero;
`else
    logic w_unused_flags;
    assign w_unused_flags     = w_carry;
    assign exec_bus.CarryFlag = 1'b0;
    assign exec_bus.ZeroFlag  = 1'b0;
`endif

    assign exec_bus.Busy   = (r_state != StIdle);
    assign exec_bus.Done   = r_wr_en;
    assign exec_bus.WrEn   = r_wr_en;
    assign exec_bus.WrAddr = r_wr_addr;
    assign exec_bus.WrData = r_wr_data;
endmodule
